extamp_cat: RTL and testbench

//  Parametrised external-amplifier band-control sender. Watches the TX frequency and PTT,

---
 rtl/extamp_pkg.sv | 11 +
 rtl/extamp_cat_uart_tx8.sv | 41 ++++
 rtl/extamp_cat.sv | 131 +++++++++++++
 tb/tb_extamp_cat.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/extamp_pkg.sv
// extamp_pkg: shared constants, FSM encoding and BCD digit helper for the amplifier CAT sender
package extamp_pkg;
  localparam logic [7:0] ASC_F = 8'h46, ASC_A = 8'h41, ASC_SEMI = 8'h3B, ASC_ZERO = 8'h30;
  localparam logic [7:0] CIV_PRE = 8'hFE, CIV_CTL = 8'hE0, CIV_CMD = 8'h00, CIV_END = 8'hFD;
  localparam int MAX_FRAME = 19;
  localparam int CIV_LEN = 11;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_HOLD} state_t;
  function automatic logic [3:0] bcd_digit(input logic [39:0] bcd, input int idx);
    return (idx >= 0 && idx < 10) ? 4'(bcd >> (4 * idx)) : 4'd0;
  endfunction
endpackage

// File: rtl/extamp_cat_uart_tx8.sv
// uart_tx8: 8N1 byte transmitter; ports clk, rst_n, start_i/data_i (load), ready_o, txd_o (pin idles at TX_INVERT)
module uart_tx8 #(
  parameter int DIV = 260,
  parameter int TX_INVERT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       txd_o
);
  localparam int CW = $clog2(DIV);
  logic [9:0] sh_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] bit_q;
  logic act_q;
  // ready in the last clk of the stop bit so the next byte follows with no gap
  assign ready_o = !act_q || (cnt_q == '0 && bit_q == '0);
  assign txd_o = (TX_INVERT != 0) ? sh_q[0] : ~sh_q[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q  <= '1;
      cnt_q <= '0;
      bit_q <= '0;
      act_q <= 1'b0;
    end else if (start_i && ready_o) begin
      sh_q  <= {1'b1, data_i, 1'b0};
      cnt_q <= CW'(DIV - 1);
      bit_q <= 4'd9;
      act_q <= 1'b1;
    end else if (act_q) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else if (bit_q == '0) act_q <= 1'b0;
      else begin
        sh_q  <= {1'b1, sh_q[9:1]};
        bit_q <= bit_q - 1'b1;
        cnt_q <= CW'(DIV - 1);
      end
    end
endmodule

// File: rtl/extamp_cat.sv
// extamp_cat: sends amplifier band-control CAT frames (Elecraft FA, or CI-V when EXTAMP_CIV_EN is defined)
//   ports: clk, rst_n; freq/ptt/refresh from radio control; mode/civ_addr (CI-V only);
//   busy (request until holdoff end); uart_txd (8N1 serial out)
module extamp_cat
  import extamp_pkg::*;
#(
  parameter int CLKFREQ      = 2500000,
  parameter int BAUDRATE     = 9600,
  parameter int NDIGITS      = 11,
  parameter int HOLDOFF_BITS = 20,
  parameter int TX_INVERT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] freq,
  input  logic        ptt,
  input  logic        refresh,
  input  logic        mode,
  input  logic [7:0]  civ_addr,
  output logic        busy,
  output logic        uart_txd
);
  localparam int DIV = CLKFREQ / BAUDRATE;
  localparam int HOLD_CLKS = HOLDOFF_BITS * DIV;
  localparam int HW = $clog2(HOLD_CLKS + 1);
  localparam int IW = $clog2(MAX_FRAME + 1);
  localparam logic [IW-1:0] FA_LEN = IW'(NDIGITS + 3);
  localparam logic [IW-1:0] FA_LAST = IW'(NDIGITS + 2);
  state_t state_q;
  logic [31:0] fprev_q, bin_q;
  logic [39:0] bcd_q, bcd_adj;
  logic [4:0] step_q;
  logic [IW-1:0] idx_q, nbytes;
  logic [HW-1:0] hold_q;
  logic pend_q, seen_q, ptt_q, busy_q;
  logic [7:0] fa_byte, tx_byte;
  logic tx_ready, tx_start, trig;
  assign trig = (freq != fprev_q) | refresh | pend_q;
  assign busy = busy_q;
  // byte 0 is a constant, so it launches in the last CONV clk before the BCD is final
  assign tx_start = (state_q == S_SEND && idx_q < nbytes) || (state_q == S_CONV && step_q == 5'd31);
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + (bcd_q[4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  assign fa_byte = idx_q == '0 ? ASC_F : idx_q == IW'(1) ? ASC_A : idx_q == FA_LAST ? ASC_SEMI :
                   ASC_ZERO | {4'h0, bcd_digit(bcd_q, NDIGITS + 1 - int'(idx_q))};
`ifdef EXTAMP_CIV_EN
  logic mode_q;
  logic [7:0] addr_q, civ_byte;
  int pair;
  // BCD payload bytes 5..9 carry digit pairs, least significant pair first
  assign pair = 2 * (int'(idx_q) - 5);
  assign civ_byte = idx_q < IW'(2) ? CIV_PRE : idx_q == IW'(2) ? addr_q : idx_q == IW'(3) ? CIV_CTL :
                    idx_q == IW'(4) ? CIV_CMD : idx_q == IW'(10) ? CIV_END :
                    {bcd_digit(bcd_q, pair + 1), bcd_digit(bcd_q, pair)};
  assign tx_byte = mode_q ? civ_byte : fa_byte;
  assign nbytes = mode_q ? IW'(CIV_LEN) : FA_LEN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= 1'b0;
      addr_q <= '0;
    end else if (state_q == S_IDLE && trig) begin
      mode_q <= mode;
      addr_q <= civ_addr;
    end
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, civ_addr};
  assign tx_byte = fa_byte;
  assign nbytes = FA_LEN;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      fprev_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      seen_q  <= 1'b0;
      ptt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ptt_q <= ptt;
      if ((ptt && !ptt_q) || (ptt && state_q == S_IDLE)) seen_q <= 1'b1;
      case (state_q)
        S_IDLE: if (trig) begin
          bin_q   <= freq;
          fprev_q <= freq;
          pend_q  <= 1'b0;
          bcd_q   <= '0;
          step_q  <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_CONV;
        end
        S_CONV: begin
          bcd_q  <= {bcd_adj[38:0], bin_q[31]};
          bin_q  <= bin_q << 1;
          step_q <= step_q + 1'b1;
          if (step_q == 5'd31) begin
            idx_q   <= IW'(1);
            state_q <= S_SEND;
          end
        end
        S_SEND: if (tx_ready) begin
          if (idx_q < nbytes) idx_q <= idx_q + 1'b1;
          else begin
            hold_q  <= HW'(HOLD_CLKS - 1);
            state_q <= S_HOLD;
            if (seen_q) begin
              pend_q <= 1'b1;
              seen_q <= 1'b0;
            end
          end
        end
        default: if (hold_q == '0) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end else hold_q <= hold_q - 1'b1;
      endcase
      if (state_q != S_IDLE && ((freq != fprev_q) || refresh)) pend_q <= 1'b1;
    end
  uart_tx8 #(.DIV(DIV), .TX_INVERT(TX_INVERT)) u_tx (
    .clk(clk), .rst_n(rst_n), .start_i(tx_start), .data_i(tx_byte), .ready_o(tx_ready), .txd_o(uart_txd)
  );
endmodule

// File: tb/tb_extamp_cat.sv
// tb_extamp_cat: directed self-checking bench for extamp_cat (DIV = 2500000/200000 truncated = 12)
module tb_extamp_cat;
  localparam int DIV = 12;
  localparam int HOLD_WAIT = 241;
  logic clk = 1'b0, rst_n = 1'b1, ptt = 1'b0, refresh = 1'b0, mode = 1'b0, busy, uart_txd;
  logic [31:0] freq = '0;
  logic [7:0] civ_addr = '0;
  int cyc = 0, errors = 0, checks = 0;
  extamp_cat #(.CLKFREQ(2500000), .BAUDRATE(200000), .NDIGITS(11), .HOLDOFF_BITS(20), .TX_INVERT(1)) dut (
    .clk(clk), .rst_n(rst_n), .freq(freq), .ptt(ptt), .refresh(refresh), .mode(mode),
    .civ_addr(civ_addr), .busy(busy), .uart_txd(uart_txd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_frame(input string tag, input logic [151:0] exp, input int nb, input int wexp);
    logic [9:0] bits;
    logic ok;
    int n, t0, w;
    t0 = 0;
    for (int i = 0; i < nb; i++) begin
      w = (i == 0) ? wexp : 1;
      n = 0;
      while (uart_txd && n <= w + 2) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("%s wait%0d", tag, i), n, w);
      if (uart_txd) return;
      if (i == 0) t0 = cyc;
      chk($sformatf("%s busy%0d", tag, i), 32'(busy), 1);
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
        bits[k] = uart_txd;
        for (int c = 1; c < DIV; c++) begin
          @(negedge clk);
          if (uart_txd !== bits[k]) ok = 1'b0;
        end
        if (k < 9) @(negedge clk);
      end
      chk($sformatf("%s framing%0d", tag, i), 32'({bits[9], bits[0], ok}), 32'b101);
      chk($sformatf("%s byte%0d", tag, i), 32'(bits[8:1]), 32'(exp[8*(nb-1-i) +: 8]));
    end
    chk({tag, " length"}, cyc - t0 + 1, nb * DIV * 10);
  endtask
  task automatic wait_busy(input string tag);
    int n = 0;
    while (busy && n <= HOLD_WAIT + 2) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, HOLD_WAIT);
  endtask
  task automatic quiet(input string tag, input int len);
    logic ok = 1'b1;
    repeat (len) begin
      @(negedge clk);
      if (!uart_txd || busy) ok = 1'b0;
    end
    chk(tag, 32'(ok), 1);
  endtask
  task automatic pulse_refresh();
    @(negedge clk) refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", 32'(uart_txd), 1);
    chk("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    quiet("idle freq0", 200);
    @(negedge clk) freq = 32'd14074000;
    check_frame("t1", 152'("FA00014074000;"), 14, 33);
    wait_busy("t1 holdoff");
    pulse_refresh();
    fork
      check_frame("t2a", 152'("FA00014074000;"), 14, 32);
      begin
        repeat (300) @(negedge clk);
        freq = 32'd7074000;
        repeat (600) @(negedge clk);
        freq = 32'd3573000;
      end
    join
    wait_busy("t2a holdoff");
    check_frame("t2b", 152'("FA00003573000;"), 14, 33);
    wait_busy("t2b holdoff");
    quiet("t2 no third", 400);
    pulse_refresh();
    fork
      check_frame("t3a", 152'("FA00003573000;"), 14, 32);
      begin
        repeat (500) @(negedge clk);
        ptt = 1'b1;
        @(negedge clk) ptt = 1'b0;
      end
    join
    wait_busy("t3a holdoff");
    check_frame("t3b", 152'("FA00003573000;"), 14, 33);
    wait_busy("t3b holdoff");
    quiet("t3 no third", 400);
    @(negedge clk) freq = 32'd50313000;
    check_frame("t4a", 152'("FA00050313000;"), 14, 33);
    wait_busy("t4a holdoff");
    pulse_refresh();
    check_frame("t4b", 152'("FA00050313000;"), 14, 32);
    wait_busy("t4b holdoff");
    @(negedge clk);
    freq = 32'd14074000;
    refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
    check_frame("t4c", 152'("FA00014074000;"), 14, 32);
    wait_busy("t4c holdoff");
    quiet("t4 single", 400);
`ifdef EXTAMP_CIV_EN
    @(negedge clk);
    mode = 1'b1;
    civ_addr = 8'h94;
    quiet("t5 mode no trigger", 200);
    pulse_refresh();
    check_frame("t5", 152'({8'hFE, 8'hFE, 8'h94, 8'hE0, 8'h00, 8'h00, 8'h40, 8'h07, 8'h14, 8'h00, 8'hFD}), 11, 32);
    wait_busy("t5 holdoff");
    mode = 1'b0;
`endif
    @(negedge clk) freq = 32'd50313000;
    repeat (516) @(negedge clk);
    chk("t6 start bit byte4", 32'(uart_txd), 0);
    rst_n = 1'b0;
    #1;
    chk("t6 reset txd", 32'(uart_txd), 1);
    chk("t6 reset busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t6 held txd", 32'(uart_txd), 1);
    rst_n = 1'b1;
    check_frame("t6", 152'("FA00050313000;"), 14, 33);
    wait_busy("t6 holdoff");
    quiet("t6 quiet", 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
